// File: rtl/reset_request_ctrl.sv
// reset_request_ctrl: merges button, watchdog and keyed sw reset sources
// into one fixed-length request pulse. Watchdog built only with RESET_WDT_EN.
module reset_request_ctrl #(
  parameter int         WDT_WIDTH = 16,
  parameter int         PULSE_LEN = 8,
  parameter logic [7:0] SW_KEY    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset_in_n,
  input  logic                 ext_req_n,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_timeout,
  input  logic                 sw_req,
  input  logic [7:0]           sw_key,
  input  logic                 sys_rst_n,
  input  logic                 cause_clr,
  output logic                 rst_req,
  output logic [2:0]           cause,
  output logic                 busy,
  output logic                 key_err
);

  localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PCW-1:0] PLOAD = PCW'(PULSE_LEN - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic           r_ext_s1;
  logic           r_ext_s2;
  logic [1:0]     r_state;
  logic [PCW-1:0] r_pcnt;
  logic           r_seen_low;
  logic           r_rst_req;
  logic           r_busy;
  logic [2:0]     r_cause;
  logic           r_key_err;

  logic           w_ext_trig;
  logic           w_sw_trig;
  logic           w_wdt_trig;
  logic           w_key_bad;
  logic           w_fire;
  logic           w_rel_done;
  logic [1:0]     w_state_nxt;
  logic [PCW-1:0] w_pcnt_nxt;
  logic           w_seen_nxt;

  // Button passes through a 2-flop synchronizer, idle-high
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_ext_s1 <= 1'b1;
      r_ext_s2 <= 1'b1;
    end else begin
      r_ext_s1 <= ext_req_n;
      r_ext_s2 <= r_ext_s1;
    end
  end

  assign w_ext_trig = ~r_ext_s2;
  assign w_sw_trig  = sw_req & (sw_key == SW_KEY);
  assign w_key_bad  = sw_req & (sw_key != SW_KEY);
  assign w_rel_done = (r_state == S_WAIT) & r_seen_low & sys_rst_n;

`ifdef RESET_WDT_EN
  logic [WDT_WIDTH-1:0] r_wdt_cnt;
  logic                 r_wdt_en_d;
  logic                 w_wdt_load;

  assign w_wdt_load = wdt_kick | (wdt_en & ~r_wdt_en_d) | w_rel_done;
  assign w_wdt_trig = wdt_en & ~wdt_kick & (r_wdt_cnt == '0);

  // Watchdog: reload on kick/enable/release, count down only while idle
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_wdt_cnt  <= '1;
      r_wdt_en_d <= 1'b0;
    end else begin
      r_wdt_en_d <= wdt_en;
      if (w_wdt_load)
        r_wdt_cnt <= wdt_timeout;
      else if (wdt_en && (r_state == S_IDLE) && (r_wdt_cnt != '0))
        r_wdt_cnt <= r_wdt_cnt - 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused   = &{1'b0, wdt_en, wdt_kick, wdt_timeout};
  assign w_wdt_trig = 1'b0;
`endif

  assign w_fire = (r_state == S_IDLE) & (w_ext_trig | w_sw_trig | w_wdt_trig);

  // Next-state for the request sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_seen_nxt  = r_seen_low;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_ASSERT;
          w_pcnt_nxt  = PLOAD;
        end
      end
      S_ASSERT: begin
        if (r_pcnt == '0)
          w_state_nxt = S_WAIT;
        else
          w_pcnt_nxt = r_pcnt - 1'b1;
      end
      S_WAIT: begin
        if (w_rel_done) begin
          w_state_nxt = S_IDLE;
          w_seen_nxt  = 1'b0;
        end else if (!sys_rst_n) begin
          w_seen_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State plus outputs registered together from the next state
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_state    <= S_IDLE;
      r_pcnt     <= '0;
      r_seen_low <= 1'b0;
      r_rst_req  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_seen_low <= w_seen_nxt;
      r_rst_req  <= (w_state_nxt == S_ASSERT);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Sticky cause; a new set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_cause <= 3'b000;
    end else if (w_fire) begin
      r_cause <= (cause_clr ? 3'b000 : r_cause)
               | {w_sw_trig, w_wdt_trig, w_ext_trig};
    end else if (cause_clr) begin
      r_cause <= 3'b000;
    end
  end

  // One-cycle flag for a software request with the wrong key
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n)
      r_key_err <= 1'b0;
    else
      r_key_err <= w_key_bad;
  end

  assign rst_req = r_rst_req;
  assign busy    = r_busy;
  assign cause   = r_cause;
  assign key_err = r_key_err;

endmodule

// File: tb/tb_reset_request_ctrl.sv
// tb_reset_request_ctrl: directed + random stimulus against a
// cycle-level behavioural model of the reset request controller.
module tb_reset_request_ctrl;

  localparam int W  = 16;
  localparam int PL = 8;
  localparam logic [7:0] KEY = 8'hA5;

  logic         clk = 1'b0;
  logic         reset_in_n;
  logic         ext_req_n;
  logic         wdt_en;
  logic         wdt_kick;
  logic [W-1:0] wdt_timeout;
  logic         sw_req;
  logic [7:0]   sw_key;
  logic         sys_rst_n;
  logic         cause_clr;
  logic         rst_req;
  logic [2:0]   cause;
  logic         busy;
  logic         key_err;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  reset_request_ctrl #(
    .WDT_WIDTH(W), .PULSE_LEN(PL), .SW_KEY(KEY)
  ) dut (
    .clk(clk), .reset_in_n(reset_in_n), .ext_req_n(ext_req_n),
    .wdt_en(wdt_en), .wdt_kick(wdt_kick), .wdt_timeout(wdt_timeout),
    .sw_req(sw_req), .sw_key(sw_key), .sys_rst_n(sys_rst_n),
    .cause_clr(cause_clr), .rst_req(rst_req), .cause(cause),
    .busy(busy), .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 requesting (m_left cycles remain),
  // 2 waiting for a full system reset.
  int       m_phase;
  int       m_left;
  bit       m_seen;
  logic [2:0] m_cause;
  bit       m_kerr;
  bit       m_s0, m_s1;
  int       m_wdt;
  bit       m_en_prev;

  task automatic model_step();
    bit ext_t, sw_t, wdt_t, fire, rel;
    int old;
    ext_t = !m_s1;
    sw_t  = sw_req && (sw_key == KEY);
    wdt_t = 1'b0;
`ifdef RESET_WDT_EN
    wdt_t = wdt_en && (m_wdt == 0) && !wdt_kick;
`endif
    old  = m_phase;
    fire = (m_phase == 0) && (ext_t || sw_t || wdt_t);
    rel  = 1'b0;
    if (cause_clr) m_cause = 3'b000;
    if (fire) m_cause = m_cause | {sw_t, wdt_t, ext_t};
    if (m_phase == 0) begin
      if (fire) begin
        m_phase = 1;
        m_left  = PL;
      end
    end else if (m_phase == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = 2;
    end else begin
      if (m_seen && sys_rst_n) begin
        m_phase = 0;
        m_seen  = 1'b0;
        rel     = 1'b1;
      end else if (!sys_rst_n) begin
        m_seen = 1'b1;
      end
    end
    if (wdt_kick || (wdt_en && !m_en_prev) || rel)
      m_wdt = int'(wdt_timeout);
    else if (wdt_en && old == 0 && m_wdt > 0)
      m_wdt = m_wdt - 1;
    m_en_prev = wdt_en;
    m_kerr = sw_req && (sw_key != KEY);
    m_s1 = m_s0;
    m_s0 = ext_req_n;
  endtask

  always @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      m_phase = 0; m_left = 0; m_seen = 1'b0;
      m_cause = 3'b000; m_kerr = 1'b0;
      m_s0 = 1'b1; m_s1 = 1'b1;
      m_wdt = (1 << W) - 1; m_en_prev = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rst_req", rst_req, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("cause", cause, m_cause);
      chk("key_err", key_err, m_kerr);
    end
  end

  task automatic sw_pulse(logic [7:0] k);
    sw_req = 1'b1; sw_key = k;
    @(negedge clk);
    sw_req = 1'b0; sw_key = 8'h00;
  endtask

  task automatic sys_reset();
    int k = 0;
    while (!(busy && !rst_req) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_rel_reached", k < 40, 1);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_sysrst", busy, 1);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_sysrst", busy, 0);
  endtask

  initial begin
    int cnt;
    reset_in_n = 1'b0; ext_req_n = 1'b1; wdt_en = 1'b0;
    wdt_kick = 1'b0; wdt_timeout = '0; sw_req = 1'b0;
    sw_key = 8'h00; sys_rst_n = 1'b1; cause_clr = 1'b0;
    #1;
    chk("rst_rst_req", rst_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cause", cause, 0);
    chk("rst_key_err", key_err, 0);
    repeat (3) @(negedge clk);
    reset_in_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // software request, exact pulse length
    sw_pulse(KEY);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (rst_req) cnt++;
      @(negedge clk);
    end
    chk("sw_pulse_len", cnt, PL);
    chk("sw_cause", cause, 3'b100);
    sys_reset();
    chk("cause_kept_sysrst", cause, 3'b100);

    // wrong key
    sw_pulse(8'h00);
    chk("key_err_pulse", key_err, 1);
    chk("bad_key_no_req", rst_req, 0);
    @(negedge clk);
    chk("key_err_one_cycle", key_err, 0);
    chk("bad_key_cause", cause, 3'b100);

    // clear alone
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    chk("clr_alone", cause, 3'b000);

    // button latency through synchronizer
    ext_req_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("ext_lat2", rst_req, 0);
    @(negedge clk);
    chk("ext_lat3", rst_req, 1);
    chk("ext_cause", cause, 3'b001);
    ext_req_n = 1'b1;
    sys_reset();

    // clear and set together, second request during pulse ignored
    cause_clr = 1'b1; sw_req = 1'b1; sw_key = KEY;
    @(negedge clk);
    cause_clr = 1'b0; sw_req = 1'b0;
    chk("clr_and_set", cause, 3'b100);
    @(negedge clk);
    sw_pulse(KEY);
    sys_reset();
    repeat (3) @(negedge clk);
    chk("no_requeue", rst_req, 0);

    // simultaneous button + sw, button held across release
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    ext_req_n = 1'b0;
    repeat (2) @(negedge clk);
    sw_pulse(KEY);
    chk("simul_req", rst_req, 1);
    chk("simul_cause", cause, 3'b101);
    sys_reset();
    @(negedge clk);
    chk("held_retrigger", rst_req, 1);
    ext_req_n = 1'b1;
    sys_reset();

    // power-on reset in the middle of a pulse
    sw_pulse(KEY);
    repeat (2) @(negedge clk);
    #2 reset_in_n = 1'b0;
    #1;
    chk("por_drop_req", rst_req, 0);
    chk("por_cause", cause, 3'b000);
    chk("por_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_in_n = 1'b1;
    @(negedge clk);
    chk("por_idle", busy, 0);

`ifdef RESET_WDT_EN
    // watchdog expiry 11 cycles after load
    wdt_timeout = 16'd10; wdt_en = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!rst_req && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("wdt_expiry_cycles", cnt, 11);
    chk("wdt_cause", cause, 3'b010);
    wdt_en = 1'b0;
    sys_reset();
    // regular kicks keep it quiet
    wdt_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 5 == 0);
      @(negedge clk);
      if (rst_req) cnt++;
    end
    wdt_kick = 1'b0; wdt_en = 1'b0;
    chk("wdt_kicked_quiet", cnt, 0);
`else
    // watchdog inputs have no effect
    wdt_timeout = 16'd2; wdt_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rst_req) cnt++;
    end
    wdt_en = 1'b0;
    chk("nowdt_quiet", cnt, 0);
    chk("nowdt_cause1", cause[1], 0);
`endif

    // random soak against the model
    for (int i = 0; i < 400; i++) begin
      ext_req_n   = ($urandom % 16) != 0;
      sw_req      = ($urandom % 8) == 0;
      sw_key      = ($urandom % 2) ? KEY : 8'($urandom);
      cause_clr   = ($urandom % 16) == 0;
      sys_rst_n   = ($urandom % 3) != 0;
      wdt_en      = ($urandom % 8) != 0;
      wdt_kick    = ($urandom % 6) == 0;
      wdt_timeout = W'($urandom_range(0, 12));
      @(negedge clk);
    end
    ext_req_n = 1'b1; sw_req = 1'b0; cause_clr = 1'b0;
    sys_rst_n = 1'b1; wdt_en = 1'b0; wdt_kick = 1'b0;
    repeat (4) @(negedge clk);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
